// File: rtl/fpu_writeback_stage.sv
// ---------------------------------------------------------------------------
// fpu_writeback_stage
//
// Purpose:
//   Registered writeback stage sitting directly behind the combinational FPU
//   datapath. Each accepted result is formatted for its target register file
//   and held behind a 2-entry skid buffer (head + skid) with a valid/ready
//   handshake on both sides. Formatting:
//     - compare ops produce 0/1 for the integer regfile,
//     - FP->int converts are sign-extended from 32 to 64 bits,
//     - FP32 results are NaN-boxed (upper word forced to ones) when NANBOX=1,
//     - everything else passes through for the FP regfile.
//   Exception flags of committed results are OR-ed into a sticky fflags
//   register, which also has a CSR write port.
//
// Parameters:
//   RD_W    width of the destination register tag
//   NANBOX  1 = NaN-box FP32 results, 0 = pass the upper word unchanged
//
// Ports:
//   clk         clock, everything updates on the rising edge
//   rst         synchronous active-high reset
//   in_valid    upstream result valid
//   in_ready    stage can accept (registered; high while skid is empty)
//   in_func7    opcode that produced in_result
//   in_rd       destination register tag
//   in_result   raw FPU result (32-bit results live in bits 31:0)
//   in_flags    {NV,DZ,OF,UF,NX} raised by the FPU
//   in_cmp      compare outcome, meaningful for compare opcodes only
//   out_valid   head entry holds a result
//   out_ready   regfile/commit accepts the head entry
//   out_data    formatted writeback data
//   out_rd      destination tag of the head entry
//   out_to_int  1 = integer regfile, 0 = FP regfile
//   out_flags   exception flags of the head entry
//   flush       drop every buffered entry
//   csr_we      fflags CSR write strobe
//   csr_wdata   fflags CSR write value
//   fflags      accrued sticky exception flags
// ---------------------------------------------------------------------------
module fpu_writeback_stage #(
    parameter int RD_W   = 5,
    parameter int NANBOX = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_func7,
    input  logic [RD_W-1:0] in_rd,
    input  logic [63:0]     in_result,
    input  logic [4:0]      in_flags,
    input  logic            in_cmp,

    output logic            out_valid,
    input  logic            out_ready,
    output logic [63:0]     out_data,
    output logic [RD_W-1:0] out_rd,
    output logic            out_to_int,
    output logic [4:0]      out_flags,

    input  logic            flush,

    input  logic            csr_we,
    input  logic [4:0]      csr_wdata,
    output logic [4:0]      fflags
);

    // One buffered writeback item, already formatted.
    typedef struct packed {
        logic [63:0]     data;
        logic [RD_W-1:0] rd;
        logic            to_int;
        logic [4:0]      flags;
    } entry_t;

    // Buffer occupancy: nothing, head only, or head plus skid.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'b00,
        OCC_HEAD  = 2'b01,
        OCC_FULL  = 2'b10
    } occ_state_t;

    occ_state_t state_q;
    occ_state_t state_next;

    entry_t head_q;
    entry_t skid_q;
    entry_t fmt_entry;

    logic       in_ready_q;
    logic [4:0] fflags_q;

    logic accept;
    logic commit;
    logic load_head_from_in;
    logic load_head_from_skid;
    logic load_skid;

    assign accept = in_valid && in_ready_q;
    assign commit = out_valid && out_ready;

    // Decode the producing opcode into the register-file view of the result.
    // Formatting happens here, before storage, so both buffer slots hold
    // data that is ready to write and the output side is pure flops.
    always_comb begin
        fmt_entry        = '0;
        fmt_entry.rd     = in_rd;
        fmt_entry.flags  = in_flags;
        fmt_entry.data   = in_result;
        fmt_entry.to_int = 1'b0;
        case (in_func7)
            // FEQ/FLT/FLE single and double: boolean into the int regfile.
            7'b1010000, 7'b1010001: begin
                fmt_entry.data   = {63'b0, in_cmp};
                fmt_entry.to_int = 1'b1;
            end
            // FCVT.W[U].S / FCVT.W[U].D: 32-bit result, RV64 sign-extends.
            7'b1100000, 7'b1100001: begin
                fmt_entry.data   = {{32{in_result[31]}}, in_result[31:0]};
                fmt_entry.to_int = 1'b1;
            end
            // Single-precision results headed for the FP regfile.
            7'b0000000, 7'b0000100, 7'b0100000, 7'b1101000: begin
                if (NANBOX != 0) begin
                    fmt_entry.data = {32'hFFFF_FFFF, in_result[31:0]};
                end else begin
                    fmt_entry.data = in_result;
                end
            end
            // Double-precision results and anything unrecognised pass
            // through untouched to the FP regfile.
            default: begin
                fmt_entry.data   = in_result;
                fmt_entry.to_int = 1'b0;
            end
        endcase
    end

    // Occupancy next-state and slot load strobes. A full buffer never
    // accepts (in_ready is low), so the only move out of FULL is the skid
    // sliding into the head when the head commits. Flush wins over
    // everything, which also discards an input accepted in that cycle.
    always_comb begin
        state_next          = state_q;
        load_head_from_in   = 1'b0;
        load_head_from_skid = 1'b0;
        load_skid           = 1'b0;
        if (flush) begin
            state_next = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        load_head_from_in = 1'b1;
                        state_next        = OCC_HEAD;
                    end
                end
                OCC_HEAD: begin
                    if (commit) begin
                        if (accept) begin
                            load_head_from_in = 1'b1;
                            state_next        = OCC_HEAD;
                        end else begin
                            state_next = OCC_EMPTY;
                        end
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = OCC_FULL;
                    end
                end
                OCC_FULL: begin
                    if (commit) begin
                        load_head_from_skid = 1'b1;
                        state_next          = OCC_HEAD;
                    end
                end
                default: begin
                    state_next = OCC_EMPTY;
                end
            endcase
        end
    end

    // Occupancy register plus the registered in_ready. in_ready is computed
    // from the next occupancy so it is a true flop that reads "skid empty"
    // in the same cycle the occupancy register does.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_next;
            in_ready_q <= (state_next != OCC_FULL);
        end
    end

    // Data slots. Contents only change on a load strobe, so a stalled head
    // stays bit-stable. Flushed slots keep stale data; occupancy alone says
    // whether they mean anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_head_from_in) begin
                head_q <= fmt_entry;
            end else if (load_head_from_skid) begin
                head_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= fmt_entry;
            end
        end
    end

    // Sticky flag accrual. A CSR write replaces the accrued value but still
    // folds in the flags of a result committing in the same cycle, so a
    // commit is never lost behind a software write. Flush does not touch
    // fflags; a commit in a flush cycle is still a commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            fflags_q <= 5'b0;
        end else if (csr_we) begin
            fflags_q <= csr_wdata | (commit ? head_q.flags : 5'b0);
        end else if (commit) begin
            fflags_q <= fflags_q | head_q.flags;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != OCC_EMPTY);
    assign out_data   = head_q.data;
    assign out_rd     = head_q.rd;
    assign out_to_int = head_q.to_int;
    assign out_flags  = head_q.flags;
    assign fflags     = fflags_q;

endmodule

// File: tb/tb_fpu_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_fpu_writeback_stage
//
// Directed bench for fpu_writeback_stage: formatting per opcode class,
// latency, skid backpressure ordering, flag accrual with CSR writes, flush
// and reset. Inputs change 1 ns after a rising edge and outputs are sampled
// at that same point, i.e. they reflect the state loaded by that edge.
// ---------------------------------------------------------------------------
module tb_fpu_writeback_stage;

    localparam int RD_W = 5;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_func7;
    logic [RD_W-1:0] in_rd;
    logic [63:0]     in_result;
    logic [4:0]      in_flags;
    logic            in_cmp;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [RD_W-1:0] out_rd;
    logic            out_to_int;
    logic [4:0]      out_flags;
    logic            flush;
    logic            csr_we;
    logic [4:0]      csr_wdata;
    logic [4:0]      fflags;

    int compared;
    int mismatched;

    fpu_writeback_stage #(
        .RD_W   (RD_W),
        .NANBOX (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_func7   (in_func7),
        .in_rd      (in_rd),
        .in_result  (in_result),
        .in_flags   (in_flags),
        .in_cmp     (in_cmp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_rd     (out_rd),
        .out_to_int (out_to_int),
        .out_flags  (out_flags),
        .flush      (flush),
        .csr_we     (csr_we),
        .csr_wdata  (csr_wdata),
        .fflags     (fflags)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one upstream result.
    task automatic applyStimulus(input logic valid, input logic [6:0] func7,
                                 input logic [RD_W-1:0] rd, input logic [63:0] result,
                                 input logic [4:0] flags, input logic cmp);
        in_valid  = valid;
        in_func7  = func7;
        in_rd     = rd;
        in_result = result;
        in_flags  = flags;
        in_cmp    = cmp;
    endtask

    // One comparison of an observed output against its expected value.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        out_ready  = 1'b1;
        flush      = 1'b0;
        csr_we     = 1'b0;
        csr_wdata  = 5'b0;
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);

        // Reset values.
        tick();
        tick();
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_fflags", fflags, 0);
        checkOutput("rst_out_data", out_data, 0);
        rst = 1'b0;

        // FP32 add: NaN-boxed, FP regfile, latency 1.
        applyStimulus(1'b1, 7'b0000000, 5'd3, 64'h0000_0000_3FC0_0000, 5'b00000, 1'b0);
        tick();
        checkOutput("fadd_s_valid", out_valid, 1);
        checkOutput("fadd_s_data", out_data, 64'hFFFF_FFFF_3FC0_0000);
        checkOutput("fadd_s_to_int", out_to_int, 0);
        checkOutput("fadd_s_rd", out_rd, 3);
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        tick();
        checkOutput("fadd_s_drained", out_valid, 0);
        checkOutput("fadd_s_fflags", fflags, 0);

        // FCVT.W.S of -2 sign-extends, NX flag.
        applyStimulus(1'b1, 7'b1100000, 5'd7, 64'h0000_0000_FFFF_FFFE, 5'b00001, 1'b0);
        tick();
        checkOutput("fcvt_data", out_data, 64'hFFFF_FFFF_FFFF_FFFE);
        checkOutput("fcvt_to_int", out_to_int, 1);
        checkOutput("fcvt_flags", out_flags, 5'b00001);
        // FCMP.D back to back: head leaves while the next one enters.
        applyStimulus(1'b1, 7'b1010001, 5'd9, 64'h0000_0000_0000_1234, 5'b00000, 1'b1);
        tick();
        checkOutput("fcvt_fflags", fflags, 5'b00001);
        checkOutput("fcmp_data", out_data, 64'h1);
        checkOutput("fcmp_to_int", out_to_int, 1);
        checkOutput("fcmp_rd", out_rd, 9);
        // FP64 add passes through unboxed.
        applyStimulus(1'b1, 7'b0000001, 5'd10, 64'h4009_21FB_5444_2D18, 5'b00000, 1'b0);
        tick();
        checkOutput("fadd_d_data", out_data, 64'h4009_21FB_5444_2D18);
        checkOutput("fadd_d_to_int", out_to_int, 0);
        // Positive convert keeps a zero upper word.
        applyStimulus(1'b1, 7'b1100001, 5'd11, 64'h0000_0000_7FFF_FFFF, 5'b00000, 1'b0);
        tick();
        checkOutput("fcvt_pos_data", out_data, 64'h0000_0000_7FFF_FFFF);
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        tick();
        checkOutput("seq_drained", out_valid, 0);

        // Clear fflags through the CSR port.
        csr_we    = 1'b1;
        csr_wdata = 5'b00000;
        tick();
        csr_we = 1'b0;
        checkOutput("csr_clear", fflags, 0);

        // Backpressure: A to head, B to skid, C held upstream.
        out_ready = 1'b0;
        applyStimulus(1'b1, 7'b0000001, 5'd1, 64'hAAAA, 5'b10000, 1'b0);
        tick();
        checkOutput("bp_a_head_rd", out_rd, 1);
        checkOutput("bp_ready_after_a", in_ready, 1);
        applyStimulus(1'b1, 7'b0000001, 5'd2, 64'hBBBB, 5'b00100, 1'b0);
        tick();
        checkOutput("bp_ready_after_b", in_ready, 0);
        checkOutput("bp_head_still_a", out_data, 64'hAAAA);
        applyStimulus(1'b1, 7'b0000001, 5'd3, 64'hCCCC, 5'b00001, 1'b0);
        tick();
        checkOutput("bp_hold_rd", out_rd, 1);
        checkOutput("bp_hold_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_b_head_rd", out_rd, 2);
        checkOutput("bp_b_head_data", out_data, 64'hBBBB);
        checkOutput("bp_fflags_a", fflags, 5'b10000);
        checkOutput("bp_ready_reopen", in_ready, 1);
        tick();
        checkOutput("bp_c_head_rd", out_rd, 3);
        checkOutput("bp_c_head_data", out_data, 64'hCCCC);
        checkOutput("bp_fflags_ab", fflags, 5'b10100);
        // C commits (flags 00001) alongside a CSR write of 00010.
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        csr_we    = 1'b1;
        csr_wdata = 5'b00010;
        tick();
        csr_we = 1'b0;
        checkOutput("csr_with_commit", fflags, 5'b00011);
        checkOutput("bp_drained", out_valid, 0);

        // Flush with both entries occupied.
        out_ready = 1'b0;
        applyStimulus(1'b1, 7'b0000001, 5'd4, 64'hDDDD, 5'b01000, 1'b0);
        tick();
        applyStimulus(1'b1, 7'b0000001, 5'd5, 64'hEEEE, 5'b01000, 1'b0);
        tick();
        checkOutput("fl_full_ready", in_ready, 0);
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        flush = 1'b1;
        tick();
        checkOutput("fl_out_valid", out_valid, 0);
        checkOutput("fl_in_ready", in_ready, 1);
        checkOutput("fl_fflags", fflags, 5'b00011);
        // Input accepted during a flush cycle is discarded.
        applyStimulus(1'b1, 7'b0000001, 5'd6, 64'hFFFF, 5'b10000, 1'b0);
        tick();
        flush = 1'b0;
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        checkOutput("fl_discard_valid", out_valid, 0);
        tick();
        checkOutput("fl_discard_stays", out_valid, 0);

        // Reset with skid full and fflags all set.
        csr_we    = 1'b1;
        csr_wdata = 5'b11111;
        tick();
        csr_we = 1'b0;
        checkOutput("pre_rst_fflags", fflags, 5'b11111);
        applyStimulus(1'b1, 7'b1010000, 5'd12, 64'h0, 5'b00010, 1'b1);
        tick();
        applyStimulus(1'b1, 7'b1100000, 5'd13, 64'h8000_0000, 5'b00001, 1'b0);
        tick();
        checkOutput("pre_rst_full", in_ready, 0);
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst2_out_valid", out_valid, 0);
        checkOutput("rst2_in_ready", in_ready, 1);
        checkOutput("rst2_fflags", fflags, 0);
        checkOutput("rst2_out_data", out_data, 0);
        checkOutput("rst2_out_rd", out_rd, 0);
        checkOutput("rst2_out_to_int", out_to_int, 0);
        checkOutput("rst2_out_flags", out_flags, 0);

        // First post-reset input emerges one cycle later.
        out_ready = 1'b1;
        applyStimulus(1'b1, 7'b0000100, 5'd6, 64'h0000_0000_4049_0FDB, 5'b00000, 1'b0);
        tick();
        checkOutput("post_rst_valid", out_valid, 1);
        checkOutput("post_rst_data", out_data, 64'hFFFF_FFFF_4049_0FDB);
        applyStimulus(1'b0, 7'b0, '0, 64'h0, 5'b0, 1'b0);
        tick();
        checkOutput("post_rst_drained", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fpu_writeback_stage.md
Name: fpu_writeback_stage

Overview:
Registered stage directly downstream of the combinational FPU datapath (adders, compare, converts). Captures each FPU result with its exception flags and destination tag behind a 2-entry skid buffer, using a valid/ready handshake. Formats data for the target register file: NaN-boxes FP32 results, sign-extends 32-bit integer converts, and turns compare into 0/1. Accrues sticky exception flags (fflags) on commit and exposes a CSR read/write port.

Parameters:
RD_W, 5, width of destination register tag.
NANBOX, 1, when 1 FP32 results to FP regfile get upper 32 bits forced to all-ones; when 0 upper bits pass unchanged.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept; registered, equals "skid entry empty"
in_func7  in  7  opcode of the op that produced in_result
in_rd  in  RD_W  destination register tag
in_result  in  64  raw FPU result (FP32/INT32 results in bits 31:0, upper zero)
in_flags  in  5  {NV,DZ,OF,UF,NX} from FPU
in_cmp  in  1  compare outcome (valid for compare opcodes only)
out_valid  out  1  writeback valid
out_ready  in  1  regfile/commit accepts
out_data  out  64  formatted writeback data
out_rd  out  RD_W  destination tag
out_to_int  out  1  1 = integer regfile, 0 = FP regfile
out_flags  out  5  flags of entry at head
flush  in  1  discard all buffered entries
csr_we  in  1  fflags CSR write strobe
csr_wdata  in  5  fflags CSR write value
fflags  out  5  accrued sticky flags

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- Reset: out_valid=0, in_ready=1, fflags=0, out_data=0, out_rd=0, out_to_int=0, out_flags=0, both entries empty. Reset mid-transfer drops all entries; no flags accrue that cycle.
- Accept: in_valid && in_ready. Accepted item appears on out_* the next cycle (latency 1) if head empty or head leaves same cycle; otherwise goes to skid entry.
- Formatting, done before storage, decoded from in_func7:
  - Int dest, compare (1010000, 1010001): data = {63'b0, in_cmp}, to_int=1.
  - Int dest, FP->int convert (1100000, 1100001): data = sign-extend in_result[31:0] to 64, to_int=1.
  - FP32 dest (0000000, 0000100, 0100000, 1101000): data = {32'hFFFFFFFF, in_result[31:0]} if NANBOX, else in_result. to_int=0.
  - FP64 dest (0000001, 0000101, 0100001, 1101001) and any other func7: data = in_result, to_int=0. Flags pass unmodified.
- Head holds when out_valid && !out_ready; contents stable.
- Skid: filled when head occupied and not leaving while an input is accepted. in_ready deasserts the cycle after skid fills. Skid moves to head on the cycle head is consumed. FIFO order always preserved. Max 2 entries.
- Commit = out_valid && out_ready. On commit, fflags |= out_flags.
- CSR: csr_we sets fflags = csr_wdata | (commit ? out_flags : 0). A commit in the same cycle is never lost.
- flush: next cycle both entries empty, out_valid=0, in_ready=1. An input accepted in the flush cycle is discarded. A commit in the flush cycle still occurs and still accrues flags. fflags is otherwise unaffected.
- No combinational path from in_valid to out_valid. Only combinational path is out_ready to the internal head advance; in_ready is a flop.

Test Plan:
- FP32 add: func7=0000000, result=64'h0000_0000_3FC0_0000, flags=0, out_ready=1 -> next cycle out_data=64'hFFFF_FFFF_3FC0_0000, out_to_int=0, fflags stays 0.
- FCVT.W.S: func7=1100000, result=64'h0000_0000_FFFF_FFFE, flags=00001 -> out_data=64'hFFFF_FFFF_FFFF_FFFE, out_to_int=1, fflags=00001 after commit. FCMP.D with in_cmp=1 -> out_data=1.
- Backpressure: out_ready=0, three back-to-back inputs A,B,C -> A at head, B in skid, in_ready=0 from the cycle after B, C held upstream. Release out_ready -> order A,B,C, no drop or duplicate.
- Flag accrual: commit flags 10000 then 00100 -> fflags=10100. Same cycle as a commit with flags 00001, csr_we=1, csr_wdata=00010 -> fflags=00011.
- Flush with 2 entries buffered and out_ready=0 -> next cycle out_valid=0, in_ready=1, fflags unchanged.
- rst asserted with skid full and fflags=11111 -> next cycle all outputs at reset values. First post-reset input emerges after 1 cycle.
